// File: rtl/sprite_engine_pkg.sv
// Shared types for the sprite engine read path.
//   port_id_t : requester index carried on m_arid and in the order FIFO
//   ar_req_t  : one AR request (address widened to the largest supported width, burst len-1)
package sprite_engine_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT_DISPLAY = 1'b0;
  localparam port_id_t PORT_FETCH   = 1'b1;

  localparam int AR_ADDR_MAX = 64;

  typedef struct packed {
    logic [AR_ADDR_MAX-1:0] addr;
    logic [7:0]             len;
  } ar_req_t;

endpackage

// File: rtl/order_fifo.sv
// Grant-order FIFO: remembers which port owns each burst in flight so R beats
// can be steered back in AXI issue order.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push, din    : enqueue a port index (ignored when full unless popping the same cycle)
//   pop          : dequeue the head (ignored when empty)
//   head         : oldest entry
//   full, empty  : occupancy flags
//   count        : current occupancy
module order_fifo
  import sprite_engine_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  port_id_t               din,
  input  logic                   pop,
  output port_id_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  port_id_t          mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is fine then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-port AXI4 read arbiter. Port 0 (display) has priority; port 1 (fetcher)
// is forced a grant after STARVE_LIMIT consecutive port-0 grants while it waits.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   s0_ar*/s0_r*         : display requester AR request and R return
//   s1_ar*/s1_r*         : fetcher requester AR request and R return
//   m_ar*                : registered AR toward the AXI master, m_arid = owning port
//   m_r*                 : R channel from the AXI master, steered combinationally
//   outstanding          : bursts granted but not yet finished with RLAST
module axi_read_arbiter
  import sprite_engine_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          s0_araddr,
  input  logic [7:0]                     s0_arlen,
  input  logic                           s0_arvalid,
  output logic                           s0_arready,
  output logic [DATA_WIDTH-1:0]          s0_rdata,
  output logic [1:0]                     s0_rresp,
  output logic                           s0_rlast,
  output logic                           s0_rvalid,
  input  logic                           s0_rready,
  input  logic [ADDR_WIDTH-1:0]          s1_araddr,
  input  logic [7:0]                     s1_arlen,
  input  logic                           s1_arvalid,
  output logic                           s1_arready,
  output logic [DATA_WIDTH-1:0]          s1_rdata,
  output logic [1:0]                     s1_rresp,
  output logic                           s1_rlast,
  output logic                           s1_rvalid,
  input  logic                           s1_rready,
  output logic [ADDR_WIDTH-1:0]          m_araddr,
  output logic [7:0]                     m_arlen,
  output logic                           m_arid,
  output logic                           m_arvalid,
  input  logic                           m_arready,
  input  logic [DATA_WIDTH-1:0]          m_rdata,
  input  logic [1:0]                     m_rresp,
  input  logic                           m_rlast,
  input  logic                           m_rvalid,
  output logic                           m_rready,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          slot_free;
  logic          can_grant;
  logic          pick_fetch;
  logic          grant0;
  logic          grant1;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  port_id_t      head;
  ar_req_t       win_req;

  order_fifo #(.DEPTH(MAX_OUTSTANDING)) u_order_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (grant0 | grant1),
    .din   (grant1 ? PORT_FETCH : PORT_DISPLAY),
    .pop   (fifo_pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  // Arbitration
  assign slot_free  = ~m_arvalid | m_arready;
  assign can_grant  = slot_free & (~fifo_full | fifo_pop);
  assign pick_fetch = s1_arvalid & (~s0_arvalid | (starve_cnt == SW'(STARVE_LIMIT)));
  assign grant0     = can_grant & s0_arvalid & ~pick_fetch;
  assign grant1     = can_grant & pick_fetch;
  assign s0_arready = grant0;
  assign s1_arready = grant1;

  always_comb begin
    win_req      = '0;
    win_req.addr = AR_ADDR_MAX'(s0_araddr);
    win_req.len  = s0_arlen;
    if (grant1) begin
      win_req.addr = AR_ADDR_MAX'(s1_araddr);
      win_req.len  = s1_arlen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arid    <= 1'b0;
    end else if (grant0 | grant1) begin
      m_arvalid <= 1'b1;
      m_araddr  <= win_req.addr[ADDR_WIDTH-1:0];
      m_arlen   <= win_req.len;
      m_arid    <= grant1;
    end else if (m_arready) begin
      m_arvalid <= 1'b0;
    end
  end

  // Counts port-0 wins that happened while port 1 was waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant1 | ~s1_arvalid) begin
      starve_cnt <= '0;
    end else if (grant0 && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // R steering to the owner of the oldest burst
  assign m_rready  = ~fifo_empty & ((head == PORT_FETCH) ? s1_rready : s0_rready);
  assign fifo_pop  = m_rvalid & m_rready & m_rlast;
  assign s0_rvalid = m_rvalid & ~fifo_empty & (head == PORT_DISPLAY);
  assign s1_rvalid = m_rvalid & ~fifo_empty & (head == PORT_FETCH);
  assign s0_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rdata  = m_rdata;
  assign s1_rresp  = m_rresp;
  assign s1_rlast  = m_rlast;

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int SL = 8;
  localparam int OW = $clog2(MO) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] s0_araddr = '0, s1_araddr = '0;
  logic [7:0]    s0_arlen = '0, s1_arlen = '0;
  logic          s0_arvalid = 1'b0, s1_arvalid = 1'b0;
  logic          s0_arready, s1_arready;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [1:0]    s0_rresp, s1_rresp;
  logic          s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
  logic          s0_rready = 1'b0, s1_rready = 1'b0;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic          m_arid, m_arvalid;
  logic          m_arready = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    m_rresp = '0;
  logic          m_rlast = 1'b0, m_rvalid = 1'b0;
  logic          m_rready;
  logic [OW-1:0] outstanding;

  axi_read_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected AR register, grant-order list, starvation count.
  typedef struct {int id; int len;} burst_t;
  bit            e_arvalid;
  logic [AW-1:0] e_araddr;
  logic [7:0]    e_arlen;
  int            e_arid;
  int            starve;
  int            order[$];
  burst_t        slv[$];
  int            beat;
  bit            g0_last, g1_last, r_acc_last;
  int            p_req0, p_req1, p_ar, p_rv, p_rr;
  bit            log_en;
  int            grant_log[$];
  bit            pop_grant_seen;

  task automatic model_reset();
    e_arvalid = 0; e_araddr = '0; e_arlen = '0; e_arid = 0;
    starve = 0; order.delete(); slv.delete(); beat = 0;
    g0_last = 0; g1_last = 0; r_acc_last = 0;
  endtask

  task automatic step(input bit do_reset);
    bit nonempty, exp_rready, pop, can;
    int head, win;
    @(negedge clk);
    reset = do_reset;
    if (g0_last || do_reset) s0_arvalid = 1'b0;
    if (g1_last || do_reset) s1_arvalid = 1'b0;
    if (!do_reset && !s0_arvalid && $urandom_range(99) < p_req0) begin
      s0_arvalid = 1'b1; s0_araddr = $urandom; s0_arlen = 8'($urandom_range(3));
    end
    if (!do_reset && !s1_arvalid && $urandom_range(99) < p_req1) begin
      s1_arvalid = 1'b1; s1_araddr = $urandom; s1_arlen = 8'($urandom_range(3));
    end
    s0_rready = ($urandom_range(99) < p_rr);
    s1_rready = ($urandom_range(99) < p_rr);
    m_arready = ($urandom_range(99) < p_ar);
    if (do_reset) m_rvalid = 1'b0;
    else if (!m_rvalid || r_acc_last) begin
      if (slv.size() > 0 && $urandom_range(99) < p_rv) begin
        m_rvalid = 1'b1; m_rdata = $urandom; m_rresp = 2'($urandom_range(3));
        m_rlast = (beat == slv[0].len);
      end else begin
        m_rvalid = 1'b0;
      end
    end
    #1;
    if (do_reset) begin
      model_reset();
      return;
    end
    check("m_arvalid", m_arvalid, e_arvalid);
    if (e_arvalid) begin
      check("m_araddr", m_araddr, e_araddr);
      check("m_arlen", m_arlen, e_arlen);
      check("m_arid", m_arid, e_arid);
    end
    check("outstanding", outstanding, order.size());
    nonempty   = (order.size() > 0);
    head       = nonempty ? order[0] : 0;
    exp_rready = nonempty && (head == 1 ? s1_rready : s0_rready);
    check("m_rready", m_rready, exp_rready);
    check("s0_rvalid", s0_rvalid, m_rvalid && nonempty && head == 0);
    check("s1_rvalid", s1_rvalid, m_rvalid && nonempty && head == 1);
    if (m_rvalid && nonempty) begin
      if (head == 0) begin
        check("s0_rdata", s0_rdata, m_rdata);
        check("s0_rresp", s0_rresp, m_rresp);
        check("s0_rlast", s0_rlast, m_rlast);
      end else begin
        check("s1_rdata", s1_rdata, m_rdata);
        check("s1_rresp", s1_rresp, m_rresp);
        check("s1_rlast", s1_rlast, m_rlast);
      end
    end
    pop = m_rvalid && exp_rready && m_rlast;
    can = (!e_arvalid || m_arready) && (order.size() < MO || pop);
    win = -1;
    if (can) begin
      if (s0_arvalid && !(s1_arvalid && starve == SL)) win = 0;
      else if (s1_arvalid) win = 1;
    end
    check("s0_arready", s0_arready, win == 0);
    check("s1_arready", s1_arready, win == 1);

    // Slave side of the AXI master port
    if (e_arvalid && m_arready) slv.push_back('{e_arid, int'(e_arlen)});
    r_acc_last = m_rvalid && exp_rready;
    if (r_acc_last) begin
      if (m_rlast) begin void'(slv.pop_front()); beat = 0; end
      else beat++;
    end

    if (pop) void'(order.pop_front());
    if (pop && win >= 0 && order.size() == MO - 1) pop_grant_seen = 1;
    if (win >= 0) begin
      order.push_back(win);
      e_arvalid = 1;
      e_araddr  = (win == 1) ? s1_araddr : s0_araddr;
      e_arlen   = (win == 1) ? s1_arlen : s0_arlen;
      e_arid    = win;
      if (log_en) grant_log.push_back(win);
    end else if (m_arready) begin
      e_arvalid = 0;
    end
    if (win == 1 || !s1_arvalid) starve = 0;
    else if (win == 0 && starve < SL) starve++;
    g0_last = (win == 0);
    g1_last = (win == 1);
  endtask

  task automatic after_reset_checks();
    @(posedge clk);
    #1;
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_m_araddr", m_araddr, 0);
    check("rst_m_arlen", m_arlen, 0);
    check("rst_m_arid", m_arid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_s0_arready", s0_arready, 0);
    check("rst_s1_arready", s1_arready, 0);
  endtask

  task automatic set_knobs(input int r0, input int r1, input int ar, input int rv, input int rr);
    p_req0 = r0; p_req1 = r1; p_ar = ar; p_rv = rv; p_rr = rr;
  endtask

  initial begin
    model_reset();
    log_en = 0;
    pop_grant_seen = 0;
    set_knobs(0, 0, 100, 100, 100);

    // Reset values
    step(1);
    after_reset_checks();

    // Both ports requesting continuously: 8 display grants, then one fetch grant
    set_knobs(100, 100, 100, 100, 100);
    log_en = 1;
    for (int i = 0; i < 200 && grant_log.size() < 27; i++) step(0);
    log_en = 0;
    check("starve_grant_budget", grant_log.size() >= 27, 1);
    for (int i = 0; i < 27 && i < grant_log.size(); i++)
      check($sformatf("starve_pattern_%0d", i), grant_log[i], (i % 9 == 8) ? 1 : 0);

    // Fill the order FIFO with no R traffic, then pop and grant in the same cycle
    step(1);
    after_reset_checks();
    set_knobs(100, 100, 100, 0, 100);
    for (int i = 0; i < 20; i++) step(0);
    check("full_outstanding", outstanding, MO);
    check("full_s0_arready", s0_arready, 0);
    check("full_s1_arready", s1_arready, 0);
    set_knobs(100, 100, 100, 100, 100);
    for (int i = 0; i < 40 && !pop_grant_seen; i++) step(0);
    check("full_pop_grant_seen", pop_grant_seen, 1);

    // AR stall: register holds while m_arready is low
    set_knobs(100, 100, 0, 100, 100);
    for (int i = 0; i < 6; i++) step(0);

    // Randomized traffic mixes with occasional reset, including mid-burst
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: set_knobs(60, 60, 70, 70, 70);
        1: set_knobs(90, 30, 40, 90, 50);
        2: set_knobs(30, 90, 90, 40, 90);
        default: set_knobs(100, 100, 100, 100, 30);
      endcase
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(199) == 0) begin
          step(1);
          after_reset_checks();
        end else begin
          step(0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
